// File: rtl/lix_shr1_sink_pkg.sv
// Shared constants and helpers for the lix_shr1 drain block.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
// Contents: default data width/depth, and a clog2 helper that never returns 0
// so derived pointer/counter widths are always at least one bit.
`timescale 1ns/100ps
`default_nettype none

package lix_shr1_sink_pkg;

  localparam int LIX_W_DEF = 32;
  localparam int LIX_D_DEF = 4;

  function automatic int lix_clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lix_shr1_sink_fifo_mem.sv
// Storage array for the drain FIFO: one synchronous write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none here; the controller decides when we is asserted.
// Ports: clk_i; we/waddr/wdata write port; raddr/rdata read port. Storage is not reset.
`timescale 1ns/100ps
`default_nettype none

module lix_fifo_mem
  import lix_shr1_sink_pkg::*;
#(
  parameter  int W  = LIX_W_DEF,
  parameter  int D  = LIX_D_DEF,
  localparam int AW = lix_clog2(D)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [D];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/lix_shr1_sink.sv
// Drain end of an enable-stalled pipeline: captures i_vld/i_x into a D-entry FIFO, drives o_vld/o_z downstream.
// Latency: one cycle from write edge to o_vld/o_z; no fall-through bypass.
// Backpressure: o_en (upstream global enable) drops while the FIFO is full; decoded from registered count only.
// Ports: clk_i/rst_ni; i_vld/i_x from the pipeline; o_en back to it; o_vld/i_rdy/o_z downstream;
//        o_cnt occupancy 0..D; o_err sticky overflow/underflow flag.
`timescale 1ns/100ps
`default_nettype none

module lix_shr1_sink
  import lix_shr1_sink_pkg::*;
#(
  parameter  int W  = LIX_W_DEF,
  parameter  int D  = LIX_D_DEF,
  localparam int AW = lix_clog2(D),
  localparam int CW = lix_clog2(D + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_vld,
  input  logic [W-1:0]  i_x,
  output logic          o_en,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [W-1:0]  o_z,
  output logic [CW-1:0] o_cnt,
  output logic          o_err
);

  localparam logic [CW-1:0] CNT_FULL = CW'(D);
  localparam logic [AW-1:0] PTR_LAST = AW'(D - 1);

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          err_q, err_d;

  logic          full, empty;
  logic          wr_req, rd_req, ovf, udf, wr, rd;
  logic [W-1:0]  rd_data;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    full   = (count_q == CNT_FULL);
    empty  = (count_q == '0);
    // Upstream only advances when o_en is high, so gating by o_en consumes each item exactly once.
    wr_req = i_vld & ~full;
    rd_req = ~empty & i_rdy;
    // Unreachable by construction; kept as a guard that flags and drops the offending access.
    ovf    = wr_req & full;
    udf    = rd_req & empty;
    wr     = wr_req & ~ovf;
    rd     = rd_req & ~udf;

    count_d  = count_q + CW'(wr) - CW'(rd);
    wr_ptr_d = wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    err_d    = err_q | ovf | udf;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  lix_fifo_mem #(
    .W (W),
    .D (D)
  ) u_mem (
    .clk_i (clk_i),
    .we    (wr),
    .waddr (wr_ptr_q),
    .wdata (i_x),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign o_en  = ~full;
  assign o_vld = ~empty;
  // Mask the unreset storage so o_z is defined zero while empty.
  assign o_z   = empty ? '0 : rd_data;
  assign o_cnt = count_q;
  assign o_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lix_shr1_sink.sv
`timescale 1ns/100ps

module tb_lix_shr1_sink;

  localparam int DEP = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        i_vld;
  logic [31:0] i_x;
  logic        o_en;
  logic        o_vld;
  logic        i_rdy;
  logic [31:0] o_z;
  logic [2:0]  o_cnt;
  logic        o_err;

  always #5 clk_i = ~clk_i;

  lix_shr1_sink #(.W(32), .D(DEP)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_vld  (i_vld),
    .i_x    (i_x),
    .o_en   (o_en),
    .o_vld  (o_vld),
    .i_rdy  (i_rdy),
    .o_z    (o_z),
    .o_cnt  (o_cnt),
    .o_err  (o_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Two-stage enable-stalled upstream pipeline, modelled behaviourally.
  logic        p_vld [2];
  logic [31:0] p_dat [2];

  int unsigned q[$];        // items the sink should hold, oldest first
  int unsigned pend[$];     // items waiting to enter the pipeline
  int unsigned accepted[$]; // items that entered the pipeline, in order
  int unsigned got[$];      // items handed downstream, in order

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int unsigned sz;
    sz = q.size();
    chk("o_vld", 32'(o_vld), 32'(sz != 0));
    chk("o_z",   o_z, (sz != 0) ? q[0] : 32'h0);
    chk("o_cnt", 32'(o_cnt), sz);
    chk("o_en",  32'(o_en), 32'(sz != DEP));
    chk("o_err", 32'(o_err), 32'h0);
  endtask

  // Called at a negedge with i_rdy already set; ends at the next negedge after checking.
  task automatic tick(input bit offer);
    bit          en, wr, rd, src_v;
    logic [31:0] wdat;
    en    = (q.size() != DEP);
    src_v = offer && (pend.size() > 0);
    wr    = p_vld[1] && en;
    wdat  = p_dat[1];
    rd    = (q.size() != 0) && i_rdy;
    @(posedge clk_i);
    #1;
    if (rd) got.push_back(q.pop_front());
    if (wr) q.push_back(wdat);
    if (en) begin
      p_vld[1] = p_vld[0];
      p_dat[1] = p_dat[0];
      p_vld[0] = src_v;
      p_dat[0] = src_v ? pend[0] : 32'h0;
      if (src_v) accepted.push_back(pend.pop_front());
    end
    i_vld = p_vld[1];
    i_x   = p_dat[1];
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic drain_and_compare(input string tag);
    int budget;
    budget = 60;
    i_rdy  = 1'b1;
    while ((pend.size() > 0 || p_vld[0] || p_vld[1] || q.size() > 0) && budget > 0) begin
      tick(1'b1);
      budget--;
    end
    chk({tag, "_drain_timeout"}, 32'(budget == 0), 32'h0);
    chk({tag, "_count"}, got.size(), accepted.size());
    for (int k = 0; k < got.size() && k < accepted.size(); k++)
      chk({tag, "_order"}, got[k], accepted[k]);
    got.delete();
    accepted.delete();
  endtask

  initial begin
    int budget;
    p_vld[0] = 1'b0; p_vld[1] = 1'b0;
    p_dat[0] = '0;   p_dat[1] = '0;
    rst_ni = 1'b0;
    i_vld  = 1'b0;
    i_x    = '0;
    i_rdy  = 1'b0;
    repeat (3) @(negedge clk_i);
    check_outputs();            // reset state
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_outputs();

    // Back-to-back stream with a always-ready consumer.
    for (int k = 1; k <= 10; k++) pend.push_back(k);
    i_rdy = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick(1'b1);
      chk("cnt_le1", 32'(o_cnt <= 1), 32'h1);
    end
    drain_and_compare("b2b");

    // Consumer stalled: fill to D, upstream held, then drain.
    for (int k = 0; k < 9; k++) pend.push_back(32'h100 + k);
    i_rdy = 1'b0;
    for (int c = 0; c < 10; c++) tick(1'b1);
    chk("stall_cnt", 32'(o_cnt), DEP);
    chk("stall_en", 32'(o_en), 32'h0);
    i_rdy = 1'b1;               // first read while full; next cycle write+read
    tick(1'b1);
    tick(1'b1);
    drain_and_compare("stall");

    // Sparse input, random ready.
    for (int k = 0; k < 20; k++) pend.push_back($urandom);
    for (int c = 0; c < 90; c++) begin
      i_rdy = 1'($urandom_range(0, 1));
      tick((c % 3) == 0);
    end
    drain_and_compare("sparse");

    // Pointer wrap with a 1,0,0,1 ready pattern.
    for (int k = 0; k < 13; k++) pend.push_back(32'h200 + k);
    for (int c = 0; c < 40; c++) begin
      i_rdy = ((c % 4) == 0 || (c % 4) == 3);
      tick(1'b1);
    end
    drain_and_compare("wrap");

    // Reset with three entries held.
    for (int k = 0; k < 6; k++) pend.push_back(32'h300 + k);
    i_rdy  = 1'b0;
    budget = 20;
    while (q.size() != 3 && budget > 0) begin
      tick(1'b1);
      budget--;
    end
    chk("rst_setup_cnt", 32'(o_cnt), 32'h3);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_vld", 32'(o_vld), 32'h0);
    chk("rst_cnt", 32'(o_cnt), 32'h0);
    chk("rst_z",   o_z, 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_en",  32'(o_en), 32'h1);
    q.delete(); pend.delete(); got.delete(); accepted.delete();
    p_vld[0] = 1'b0; p_vld[1] = 1'b0;
    i_vld = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    pend.push_back(32'h55);
    i_rdy  = 1'b1;
    budget = 20;
    while (got.size() == 0 && budget > 0) begin
      tick(1'b1);
      budget--;
    end
    chk("post_rst_timeout", 32'(budget == 0), 32'h0);
    chk("post_rst_first", (got.size() > 0) ? got[0] : 32'hDEAD_BEEF, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
